// File: rtl/k054539_sdec.sv
// k054539_sdec: serial audio deserializer for the k054539 PCM output stream.
// Samples DTCK/WDCK/SDAT in the CLK domain, rebuilds signed left/right pairs,
// and reports stream lock and framing errors.
//
// Output handshake: SMP_VALID is a one-cycle strobe with no ready/backpressure;
// L_OUT/R_OUT change only in the cycle SMP_VALID is high and hold otherwise,
// so a consumer must capture the pair in that cycle. FRAME_ERR is an
// independent one-cycle strobe that may coincide with SMP_VALID.
module k054539_sdec #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             CLK,
  input  logic             NRES,
  input  logic             DTCK,
  input  logic             WDCK,
  input  logic             SDAT,
  output logic [WIDTH-1:0] L_OUT,
  output logic [WIDTH-1:0] R_OUT,
  output logic             SMP_VALID,
  output logic             FRAME_ERR,
  output logic             LOCK
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [IW-1:0] IDLE_ONE = IW'(1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] dtck_sync, wdck_sync, sdat_sync;
  logic                   s_dtck, s_wdck, s_sdat, s_dtck_d;

  logic             wd_prev;
  logic [WIDTH-1:0] word, word_ins, l_hold;
  logic [CW-1:0]    count;
  logic             have_left, left_ok;
  logic [IW-1:0]    idle;

  logic rise, bnd, in_frame, close, close_right, cnt_ok, pair_out, err, timeout;

  assign s_dtck = dtck_sync[SYNC_STAGES-1];
  assign s_wdck = wdck_sync[SYNC_STAGES-1];
  assign s_sdat = sdat_sync[SYNC_STAGES-1];

  // Event decode: all per-bit work keys off one synchronized DTCK rise.
  assign rise        = s_dtck & ~s_dtck_d;
  assign bnd         = rise & (s_wdck != wd_prev);
  assign in_frame    = (state != ST_HUNT);
  assign close       = bnd & in_frame;
  assign close_right = close & ~wd_prev;
  assign cnt_ok      = (count == CNT_FULL);
  assign pair_out    = close_right & have_left;
  assign err         = close & ~cnt_ok;
  // A rise in the same cycle clears the idle counter, so it beats the timeout.
  assign timeout     = ~rise & (idle == IDLE_MAX);
  assign LOCK        = (state == ST_LOCKED);

  // Identical synchronizer chains keep DTCK, WDCK and SDAT aligned; plus the rise-detect delay flop.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      dtck_sync <= '0;
      wdck_sync <= '0;
      sdat_sync <= '0;
      s_dtck_d  <= 1'b0;
    end else begin
      dtck_sync <= {dtck_sync[SYNC_STAGES-2:0], DTCK};
      wdck_sync <= {wdck_sync[SYNC_STAGES-2:0], WDCK};
      sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], SDAT};
      s_dtck_d  <= s_dtck;
    end
  end

  // Idle counter: cleared by every rise, otherwise counts up and saturates.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      idle <= '0;
    end else if (rise) begin
      idle <= '0;
    end else if (idle != IDLE_MAX) begin
      idle <= idle + IDLE_ONE;
    end
  end

  // Word register with the current bit written at index WIDTH-1-count; bits past WIDTH fall away.
  always_comb begin
    word_ins = word;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(count) == WIDTH - 1 - i) word_ins[i] = s_sdat;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) state <= ST_HUNT;
    else       state <= state_nxt;
  end

  // FSM next state: timeout overrides everything, otherwise lock is earned by a clean pair and lost on any framing error.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_HUNT;
    end else begin
      case (state)
        ST_HUNT:   if (bnd) state_nxt = ST_ACQ;
        ST_ACQ:    if (pair_out && left_ok && cnt_ok) state_nxt = ST_LOCKED;
        ST_LOCKED: if (err) state_nxt = ST_ACQ;
        default:   state_nxt = ST_HUNT;
      endcase
    end
  end

  // Datapath: capture bits, close words at channel boundaries, pair left with right and drive the strobes.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      wd_prev   <= 1'b0;
      word      <= '0;
      count     <= '0;
      l_hold    <= '0;
      have_left <= 1'b0;
      left_ok   <= 1'b0;
      L_OUT     <= '0;
      R_OUT     <= '0;
      SMP_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      SMP_VALID <= pair_out;
      FRAME_ERR <= err;
      if (timeout) begin
        // Stream stalled: the partial word and any pending left are dropped.
        word      <= '0;
        count     <= '0;
        have_left <= 1'b0;
      end else if (bnd) begin
        wd_prev <= s_wdck;
        word    <= {s_sdat, {(WIDTH-1){1'b0}}};
        count   <= CNT_ONE;
        if (!in_frame) begin
          // First boundary after hunting only aligns us; nothing closes.
          have_left <= 1'b0;
          left_ok   <= 1'b0;
        end else if (wd_prev) begin
          l_hold    <= word;
          have_left <= 1'b1;
          left_ok   <= cnt_ok;
        end else if (have_left) begin
          L_OUT     <= l_hold;
          R_OUT     <= word;
          have_left <= 1'b0;
        end
      end else if (rise && in_frame) begin
        word <= word_ins;
        if (count != CNT_SAT) count <= count + CNT_ONE;
      end
    end
  end

endmodule
